// File: rtl/reg_writeback_unit_pkg.sv
// Shared types and defaults for the writeback stage in front of RegisterFile.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`include "defines.vh"

package reg_writeback_unit_pkg;

  localparam int WB_WORD_SIZE    = `WORD_SIZE;
  localparam int WB_NUM_REGS     = `NUMBER_OF_REGISTERS;
  localparam int WB_STARVE_LIMIT = `WB_STARVE_LIMIT;
  localparam int WB_CNT_WIDTH    = `WB_CNT_WIDTH;

  // Which producer owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_ALU  = 2'd1,
    SEL_LD   = 2'd2
  } wb_sel_e;

endpackage

// File: rtl/defines.vh
`ifndef DEFINES_VH
`define DEFINES_VH

`define WORD_SIZE           32
`define NUMBER_OF_REGISTERS 32
`define WB_STARVE_LIMIT     2
`define WB_CNT_WIDTH        16

`endif

// File: rtl/wb_arbiter.sv
// Picks ALU or load result for the single write port; loads win unless ALU has starved.
// Latency: combinational grant; starvation counter updates on the clock edge.
// Backpressure: Stall withholds both readies; readies are forced low while rst_n is low.
//
// Ports: clk/rst_n, alu_valid/ld_valid/stall in; alu_ready/ld_ready/sel out.
module wb_arbiter
  import reg_writeback_unit_pkg::*;
#(
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    alu_valid,
  input  logic    ld_valid,
  input  logic    stall,
  output logic    alu_ready,
  output logic    ld_ready,
  output wb_sel_e sel
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt;
  logic          starved;
  wb_sel_e       grant;

  assign starved = (starve_cnt == SW'(STARVE_LIMIT));

  always_comb begin
    grant = SEL_NONE;
    if (!stall) begin
      if (starved && alu_valid) grant = SEL_ALU;
      else if (ld_valid)        grant = SEL_LD;
      else if (alu_valid)       grant = SEL_ALU;
    end
  end

  assign sel       = grant;
  assign alu_ready = rst_n && (grant == SEL_ALU);
  assign ld_ready  = rst_n && (grant == SEL_LD);

  // Counts consecutive load wins while an ALU result is waiting. Any other
  // unstalled outcome (ALU granted, or no ALU result pending) starts over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!stall) begin
      if (grant == SEL_LD && alu_valid) begin
        if (!starved) starve_cnt <= starve_cnt + SW'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// Writeback stage: merges ALU and load results onto RegisterFile's write port.
// Latency: one cycle from Valid&Ready transfer to RegWrite/WriteReg/WriteData.
// Backpressure: at most one producer sees Ready per cycle; Stall blocks both.
//
// Ports: ALU channel (AluValid/AluDest/AluData/AluReady), load channel
// (LdValid/LdDest/LdData/LdReady), Stall; registered write port
// (WriteReg/WriteData/RegWrite); bypass (SrcRegN in, FwdHitN/FwdData out);
// RetireCount of committed nonzero-destination writes.
`include "defines.vh"

module reg_writeback_unit
  import reg_writeback_unit_pkg::*;
#(
  parameter int WORD_SIZE           = `WORD_SIZE,
  parameter int NUMBER_OF_REGISTERS = `NUMBER_OF_REGISTERS,
  parameter int ADDR_WIDTH          = $clog2(NUMBER_OF_REGISTERS),
  parameter int STARVE_LIMIT        = `WB_STARVE_LIMIT,
  parameter int CNT_WIDTH           = `WB_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  AluValid,
  input  logic [ADDR_WIDTH-1:0] AluDest,
  input  logic [WORD_SIZE-1:0]  AluData,
  output logic                  AluReady,
  input  logic                  LdValid,
  input  logic [ADDR_WIDTH-1:0] LdDest,
  input  logic [WORD_SIZE-1:0]  LdData,
  output logic                  LdReady,
  input  logic                  Stall,
  output logic [ADDR_WIDTH-1:0] WriteReg,
  output logic [WORD_SIZE-1:0]  WriteData,
  output logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] SrcReg1,
  input  logic [ADDR_WIDTH-1:0] SrcReg2,
  input  logic [ADDR_WIDTH-1:0] SrcReg3,
  output logic                  FwdHit1,
  output logic                  FwdHit2,
  output logic                  FwdHit3,
  output logic [WORD_SIZE-1:0]  FwdData,
  output logic [CNT_WIDTH-1:0]  RetireCount
);

  wb_sel_e               sel;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] win_dest;
  logic [WORD_SIZE-1:0]  win_data;
  logic                  win_commit;

  wb_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (AluValid),
    .ld_valid  (LdValid),
    .stall     (Stall),
    .alu_ready (AluReady),
    .ld_ready  (LdReady),
    .sel       (sel)
  );

  // A ready is only raised for a channel that is valid, so either ready
  // implies a transfer.
  assign xfer     = AluReady || LdReady;
  assign win_dest = (sel == SEL_ALU) ? AluDest : LdDest;
  assign win_data = (sel == SEL_ALU) ? AluData : LdData;

  // r0 writes are consumed but dropped so RegisterFile never sees them.
  assign win_commit = xfer && (win_dest != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite    <= 1'b0;
      WriteReg    <= '0;
      WriteData   <= '0;
      RetireCount <= '0;
    end else begin
      RegWrite <= win_commit;
      if (xfer) begin
        WriteReg  <= win_dest;
        WriteData <= win_data;
      end
      if (win_commit) RetireCount <= RetireCount + CNT_WIDTH'(1);
    end
  end

  // Bypass covers the cycle in which the write is presented but not yet
  // readable from RegisterFile.
  assign FwdData = WriteData;
  assign FwdHit1 = RegWrite && (WriteReg == SrcReg1) && (SrcReg1 != '0);
  assign FwdHit2 = RegWrite && (WriteReg == SrcReg2) && (SrcReg2 != '0);
  assign FwdHit3 = RegWrite && (WriteReg == SrcReg3) && (SrcReg3 != '0);

endmodule

// File: doc/reg_writeback_unit.md
Name: reg_writeback_unit

Overview:
- Writeback stage directly upstream of RegisterFile.
- Merges two result producers into the register file's single write port (WriteReg/WriteData/RegWrite): the ALU result channel and the load-return channel.
- Arbitrates between them with load priority and an ALU starvation guard.
- Registers the winning write, exposes it as a one-cycle bypass to the operand-read side, and counts retired writes.

Parameters:
- WORD_SIZE, `WORD_SIZE (32): data width.
- NUMBER_OF_REGISTERS, `NUMBER_OF_REGISTERS (32): register count.
- ADDR_WIDTH, $clog2(NUMBER_OF_REGISTERS): register address width.
- STARVE_LIMIT, 2: consecutive load wins over a waiting ALU result before ALU is forced.
- CNT_WIDTH, 16: retire counter width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- AluValid  in  1  ALU result present
- AluDest  in  ADDR_WIDTH  ALU destination register
- AluData  in  WORD_SIZE  ALU result
- AluReady  out  1  ALU result accepted this cycle
- LdValid  in  1  load data present
- LdDest  in  ADDR_WIDTH  load destination register
- LdData  in  WORD_SIZE  load data
- LdReady  out  1  load accepted this cycle
- Stall  in  1  block all acceptance this cycle
- WriteReg  out  ADDR_WIDTH  to RegisterFile, registered
- WriteData  out  WORD_SIZE  to RegisterFile, registered
- RegWrite  out  1  to RegisterFile, registered
- SrcReg1/SrcReg2/SrcReg3  in  ADDR_WIDTH  read addresses being presented to RegisterFile
- FwdHit1/FwdHit2/FwdHit3  out  1  in-flight write matches SrcRegN
- FwdData  out  WORD_SIZE  in-flight write data (equals WriteData)
- RetireCount  out  CNT_WIDTH  number of committed nonzero-destination writes

Behaviour:
- Reset, async on rst_n low:
  - RegWrite=0, WriteReg=0, WriteData=0, RetireCount=0.
  - Starvation counter cleared to 0.
  - All outputs valid during reset. AluReady and LdReady are 0 while rst_n is low.
- Grant, combinational, evaluated each cycle:
  - Stall=1: no grant.
  - Otherwise, starve counter == STARVE_LIMIT and AluValid: grant ALU.
  - Otherwise, LdValid: grant load.
  - Otherwise, AluValid: grant ALU.
  - Otherwise, no grant.
  - AluReady and LdReady are 1 only for the granted channel. At most one is high.
  - A transfer occurs when Valid and Ready are both 1. Producers must hold Valid/Dest/Data stable until Ready.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, when load is granted while AluValid=1.
  - Clears when ALU is granted or AluValid=0.
  - Holds when Stall=1.
- Write register, latency one cycle from transfer:
  - On a transfer: WriteReg<=Dest, WriteData<=Data, RegWrite<=(Dest!=0).
  - No transfer: RegWrite<=0; WriteReg and WriteData hold.
  - Destination 0 is accepted and consumed but never written, and is not counted.
- RetireCount:
  - Increments on every edge where RegWrite is asserted into the register, i.e. same edge as the update above.
  - Wraps modulo 2^CNT_WIDTH.
- Forwarding, combinational from registered state:
  - FwdHitN = RegWrite && (WriteReg==SrcRegN) && (SrcRegN!=0).
  - FwdData = WriteData at all times. Consumer muxes FwdData over ReadDataN when FwdHitN=1, covering the cycle before the write lands.
- Simultaneous events:
  - Both channels valid: load wins until the counter saturates; the ALU then wins exactly one cycle.
  - Stall together with a valid input: nothing accepted, RegWrite<=0.
  - Same Dest on back-to-back cycles: each commits in order; the later value wins in RegisterFile.
- Reset mid-operation: any uncommitted grant is lost; producers re-present after rst_n rises.

Decomposition:
- Shared header defines.vh holds WORD_SIZE and NUMBER_OF_REGISTERS.
- Add to defines.vh: WB_STARVE_LIMIT (2) and WB_CNT_WIDTH (16), used as parameter defaults.
- One sub-module, wb_arbiter: grant logic plus the starvation counter. Outputs are AluReady, LdReady and the select.
- The top level holds the write register, retire counter and forward compare.

Test Plan:
- Reset: rst_n=0 with AluValid=1 -> RegWrite=0, WriteReg=0, WriteData=0, RetireCount=0, AluReady=0. Release -> first ALU write (Dest=5, Data=0x11) appears next cycle with RegWrite=1.
- Load only, Dest=3, Data=0xDEADBEEF -> LdReady=1 in cycle 0; cycle 1 RegWrite=1, WriteReg=3, WriteData=0xDEADBEEF; RetireCount=1.
- Both valid continuously, ALU Dest=7, loads Dest=8,9,10 -> grants in order Ld, Ld, ALU, Ld. Writes in that order; ALU write on the third commit.
- Dest=0: ALU Dest=0, Data=0xFF -> AluReady=1; next cycle RegWrite=0; RetireCount unchanged.
- Forward: commit Dest=4, Data=0x1234 with SrcReg1=4, SrcReg2=0, SrcReg3=6 -> FwdHit1=1, FwdHit2=0, FwdHit3=0, FwdData=0x1234.
- Stall=1 for 2 cycles with LdValid=1 -> LdReady=0 and RegWrite=0 both cycles. Stall released -> load commits one cycle later. RetireCount wraps 0xFFFF->0x0000 on the next commit when preloaded near max.
